// File: rtl/sseg_shift_driver.sv
// sseg_shift_driver: serialises NUM_DIGITS 8-bit segment patterns into an
// external shift-register chain (sclk/sdo), then pulses slatch to update the
// display outputs. Highest digit goes out first, segment AA first per byte.
// Optional build macro: SSEG_ACTIVE_LOW_EN -- when defined the captured
// frame is the bitwise inverse of seg_data (common-anode displays).
module sseg_shift_driver #(
  parameter int NUM_DIGITS = 8,
  parameter int CLK_DIV    = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [8*NUM_DIGITS-1:0] seg_data,
  output logic                    busy,
  output logic                    done,
  output logic                    sclk,
  output logic                    sdo,
  output logic                    slatch
);

  localparam int NBITS = 8 * NUM_DIGITS;
  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [7:0] BIT_LAST = 8'(NBITS - 1);

  typedef enum logic [2:0] {IDLE, SHIFT_LO, SHIFT_HI, LATCH, DONE} state_t;

  state_t             state_reg, state_next;
  logic [NBITS-1:0]   shift_reg, shift_next;
  logic [7:0]         cyc_reg, cyc_next;
  logic [7:0]         bit_reg, bit_next;
  logic [NBITS-1:0]   capture_data;
  logic               busy_reg, done_reg, sclk_reg, sdo_reg, slatch_reg;

`ifdef SSEG_ACTIVE_LOW_EN
  assign capture_data = ~seg_data;
`else
  assign capture_data = seg_data;
`endif

  // Next-state, shift register and counter update.
  always_comb begin
    state_next = state_reg;
    shift_next = shift_reg;
    bit_next   = bit_reg;
    cyc_next   = (cyc_reg == 8'd0) ? 8'd0 : cyc_reg - 8'd1;
    case (state_reg)
      IDLE, DONE: begin
        if (start) begin
          state_next = SHIFT_LO;
          shift_next = capture_data;
          cyc_next   = DIV_LAST;
          bit_next   = 8'd0;
        end else begin
          state_next = IDLE;
          cyc_next   = 8'd0;
        end
      end
      SHIFT_LO: begin
        if (cyc_reg == 8'd0) begin
          state_next = SHIFT_HI;
          cyc_next   = DIV_LAST;
        end
      end
      SHIFT_HI: begin
        if (cyc_reg == 8'd0) begin
          cyc_next = DIV_LAST;
          if (bit_reg == BIT_LAST) begin
            state_next = LATCH;
          end else begin
            state_next = SHIFT_LO;
            bit_next   = bit_reg + 8'd1;
            shift_next = {shift_reg[NBITS-2:0], 1'b0};
          end
        end
      end
      LATCH: begin
        if (cyc_reg == 8'd0) begin
          state_next = DONE;
          cyc_next   = 8'd0;
        end
      end
      default: begin
        state_next = IDLE;
        cyc_next   = 8'd0;
      end
    endcase
  end

  // State, datapath and registered outputs decoded from the upcoming state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      shift_reg  <= '0;
      cyc_reg    <= 8'd0;
      bit_reg    <= 8'd0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      sclk_reg   <= 1'b0;
      sdo_reg    <= 1'b0;
      slatch_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      shift_reg  <= shift_next;
      cyc_reg    <= cyc_next;
      bit_reg    <= bit_next;
      busy_reg   <= (state_next == SHIFT_LO) || (state_next == SHIFT_HI) ||
                    (state_next == LATCH);
      done_reg   <= (state_next == DONE);
      sclk_reg   <= (state_next == SHIFT_HI);
      sdo_reg    <= ((state_next == SHIFT_LO) || (state_next == SHIFT_HI)) ?
                    shift_next[NBITS-1] : 1'b0;
      slatch_reg <= (state_next == LATCH);
    end
  end

  assign busy   = busy_reg;
  assign done   = done_reg;
  assign sclk   = sclk_reg;
  assign sdo    = sdo_reg;
  assign slatch = slatch_reg;

endmodule

// File: tb/tb_sseg_shift_driver.sv
// Bench for sseg_shift_driver: three configurations run in parallel, each
// checked every cycle against a timeline model (cycle offset since start),
// plus directed frames with hand-computed expectations.
module tb_sseg_shift_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  for (genvar gi = 0; gi < 3; gi++) begin : g
    localparam int N  = (gi == 0) ? 2 : (gi == 1) ? 8 : 1;
    localparam int C  = (gi == 0) ? 2 : (gi == 1) ? 4 : 1;
    localparam int NB = 8 * N;
    localparam int S  = 16 * N * C;
    localparam int B  = (16 * N + 1) * C;
    localparam int RR = (NB >= 16) ? 10 : 5;
    localparam logic [63:0] LIT = (gi == 0) ? 64'hFC60 :
                                  (gi == 1) ? 64'hFC60DAF266B6BEE0 : 64'hA5;

    logic rst = 1'b1;
    logic start = 1'b0;
    logic [NB-1:0] seg_data = '0;
    logic busy, done, sclk, sdo, slatch;
    logic blk_done = 1'b0;

    sseg_shift_driver #(.NUM_DIGITS(N), .CLK_DIV(C)) dut (
      .clk(clk), .rst(rst), .start(start), .seg_data(seg_data),
      .busy(busy), .done(done), .sclk(sclk), .sdo(sdo), .slatch(slatch)
    );

    // Model: idle, or running with k = cycle offset since the accepting edge.
    logic m_run = 1'b0;
    int k = 0;
    logic [NB-1:0] frame = '0;

    function automatic logic [NB-1:0] cap(input logic [NB-1:0] x);
`ifdef SSEG_ACTIVE_LOW_EN
      return ~x;
`else
      return x;
`endif
    endfunction

    function automatic logic [4:0] expect_outs();
      logic [4:0] e;
      e = '0;
      if (m_run) begin
        if (k < S) begin
          e[4] = 1'b1;
          e[2] = ((k / C) % 2) == 1;
          e[1] = frame[NB-1-(k/(2*C))];
        end else if (k < B) begin
          e[4] = 1'b1;
          e[0] = 1'b1;
        end else begin
          e[3] = 1'b1;
        end
      end
      return e;
    endfunction

    initial forever begin
      @(posedge clk);
      if (rst) m_run = 1'b0;
      else if ((!m_run || k == B) && start) begin
        m_run = 1'b1; k = 0; frame = cap(seg_data);
      end else if (m_run && k < B) k++;
      else m_run = 1'b0;
      #1;
      chk($sformatf("g%0d_outs run=%0d k=%0d", gi, m_run, k),
          {59'd0, busy, done, sclk, sdo, slatch}, {59'd0, expect_outs()});
    end

    // Observe one frame from its first busy cycle until the done pulse.
    task automatic watch(output logic [63:0] bits, output int rises, output int busyc,
                         output int latchc, output int donej);
      logic prev;
      prev = sclk; bits = '0; rises = 0; busyc = 0; latchc = 0; donej = 0;
      for (int j = 1; j <= B + 20; j++) begin
        if (sclk && !prev) begin
          bits = {bits[62:0], sdo};
          rises++;
        end
        prev = sclk;
        busyc += int'(busy);
        latchc += int'(slatch);
        if (done) begin
          donej = j;
          break;
        end
        @(negedge clk);
      end
      if (donej == 0) chk($sformatf("g%0d_done_timeout", gi), 0, 1);
    endtask

    task automatic check_frame(input string tag, input logic [NB-1:0] d);
      logic [63:0] bits;
      int rises, busyc, latchc, donej;
      watch(bits, rises, busyc, latchc, donej);
      chk($sformatf("g%0d_%s_bits", gi, tag), bits, 64'(cap(d)));
      chk($sformatf("g%0d_%s_rises", gi, tag), 64'(rises), 64'(NB));
      chk($sformatf("g%0d_%s_busy", gi, tag), 64'(busyc), 64'(B));
      chk($sformatf("g%0d_%s_latch", gi, tag), 64'(latchc), 64'(C));
      chk($sformatf("g%0d_%s_donecyc", gi, tag), 64'(donej), 64'(B + 1));
    endtask

    task automatic frame_lit(input string tag, input logic [NB-1:0] d);
      @(negedge clk); start = 1'b1; seg_data = d;
      @(negedge clk); start = 1'b0; seg_data = NB'({$urandom(), $urandom()});
      check_frame(tag, d);
    endtask

    initial begin
      logic prev;
      int r, seen;
      repeat (3) @(negedge clk);
      chk($sformatf("g%0d_reset_outs", gi), {59'd0, busy, done, sclk, sdo, slatch}, 64'd0);
      rst = 1'b0;

      // single start pulse with the reference pattern
      frame_lit("lit", NB'(LIT));

      // start held high, data changed after capture; restart only from DONE
      @(negedge clk); start = 1'b1; seg_data = NB'(LIT);
      @(negedge clk); seg_data = '0;
      check_frame("hold", NB'(LIT));
      @(negedge clk);
      chk($sformatf("g%0d_restart_busy", gi), 64'(busy), 64'd1);
      start = 1'b0;
      check_frame("hold2", '0);

      // reset mid-frame at an sclk rise
      @(negedge clk); start = 1'b1; seg_data = NB'(LIT);
      @(negedge clk); start = 1'b0;
      prev = 1'b0; r = 0;
      for (int j = 0; j < B + 10 && r < RR; j++) begin
        if (sclk && !prev) r++;
        prev = sclk;
        if (r < RR) @(negedge clk);
      end
      chk($sformatf("g%0d_abort_rises", gi), 64'(r), 64'(RR));
      rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      chk($sformatf("g%0d_abort_outs", gi), {59'd0, busy, done, sclk, sdo, slatch}, 64'd0);
      seen = 0;
      repeat (B + 4) begin
        @(negedge clk);
        seen += int'(slatch | done | busy);
      end
      chk($sformatf("g%0d_abort_quiet", gi), 64'(seen), 64'd0);
      frame_lit("after_abort", NB'(LIT));

      // randomized traffic, checked by the per-cycle model
      repeat (4000) begin
        @(negedge clk);
        start = ($urandom_range(0, 7) == 0);
        seg_data = NB'({$urandom(), $urandom()});
        rst = ($urandom_range(0, 599) == 0);
      end
      @(negedge clk); start = 1'b0; rst = 1'b0;
      repeat (B + 4) @(negedge clk);
      blk_done = 1'b1;
    end
  end

  initial begin
    logic all_done;
    all_done = 1'b0;
    for (int t = 0; t < 60000 && !all_done; t++) begin
      @(negedge clk);
      all_done = g[0].blk_done && g[1].blk_done && g[2].blk_done;
    end
    chk("all_blocks_finished", 64'(all_done), 64'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
